// File: rtl/capture_pkg.sv
// Shared definitions for the linear-sensor capture scheduler.
// Holds the state encoding and the sensor timing constants.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int SENSOR_CYCLE_LEN    = 577;
    localparam int DEFAULT_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal-compare flag.
// 'reached' is high whenever the count is at or beyond 'term'.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         reached
);

    logic [W-1:0] count;

    // Count up while enabled, hold at all-ones instead of wrapping
    always_ff @(posedge clk_in) begin
        if (reset_in || clear) begin
            count <= {W{1'b0}};
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

    assign reached = (count >= term);

endmodule

// File: rtl/capture_scheduler.sv
// Issues start_capture pulses to the sensor reader in single-shot or continuous
// mode, tracks completion and timeout, and reports frame count and sticky errors.
module capture_scheduler
    import capture_pkg::*;
#(
    parameter int PERIOD_W    = 16,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int FCNT_W      = 16
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                enable,
    input  logic                continuous,
    input  logic                sw_trigger,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear_err,
    input  logic                capture_complete,
    output logic                start_capture,
    output logic                busy,
    output logic                frame_done,
    output logic [FCNT_W-1:0]   frame_count,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TO_W-1:0] TO_TERM = TO_W'(TIMEOUT_CYC - 1);

    state_t              state;
    logic [PERIOD_W-1:0] per_reg;
    logic [PERIOD_W-1:0] per_term;
    logic                per_done;
    logic                to_done;
    logic                expired;
    logic                enter_start;
    logic                ovr_evt;
    logic                to_evt;

    // Expiry compare point: start-to-start interval minus one, floored at zero
    always_comb begin
        per_term = {PERIOD_W{1'b0}};
        if (per_reg != {PERIOD_W{1'b0}}) begin
            per_term = per_reg - PERIOD_W'(1);
        end else begin
            per_term = {PERIOD_W{1'b0}};
        end
    end

    // Timers are cleared on the edge entering START so they read 0 during START
    always_comb begin
        enter_start = 1'b0;
        if (enable) begin
            case (state)
                ST_IDLE: enter_start = continuous | sw_trigger;
                ST_HOLD: enter_start = continuous & per_done;
                default: enter_start = 1'b0;
            endcase
        end else begin
            enter_start = 1'b0;
        end
    end

    // Error events; period expiry only counts once per frame and only when free-running
    always_comb begin
        ovr_evt = 1'b0;
        to_evt  = 1'b0;
        if (enable) begin
            ovr_evt = ((state == ST_WAIT) && continuous && per_done && !expired)
                   || (((state == ST_START) || (state == ST_WAIT)) && !continuous && sw_trigger);
            to_evt  = (state == ST_WAIT) && to_done && !capture_complete;
        end else begin
            ovr_evt = 1'b0;
            to_evt  = 1'b0;
        end
    end

    sat_counter #(.W(PERIOD_W)) u_period_timer (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear    (enter_start),
        .en       (state != ST_IDLE),
        .term     (per_term),
        .reached  (per_done)
    );

    sat_counter #(.W(TO_W)) u_timeout_timer (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear    (enter_start),
        .en       ((state == ST_START) || (state == ST_WAIT)),
        .term     (TO_TERM),
        .reached  (to_done)
    );

    // Scheduler FSM with registered outputs
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= ST_IDLE;
            per_reg       <= {PERIOD_W{1'b0}};
            expired       <= 1'b0;
            start_capture <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_count   <= {FCNT_W{1'b0}};
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            start_capture <= 1'b0;
            frame_done    <= 1'b0;

            if (ovr_evt) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end

            if (to_evt) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end else begin
                timeout_err <= timeout_err;
            end

            if (state == ST_START) begin
                expired <= 1'b0;
            end else if ((state == ST_WAIT) && per_done) begin
                expired <= 1'b1;
            end else begin
                expired <= expired;
            end

            if (!enable) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enter_start) begin
                            state         <= ST_START;
                            start_capture <= 1'b1;
                            busy          <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    ST_START: begin
                        state   <= ST_WAIT;
                        per_reg <= period;
                        busy    <= 1'b1;
                    end
                    ST_WAIT: begin
                        if (capture_complete) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + FCNT_W'(1);
                            busy        <= 1'b0;
                            state       <= continuous ? ST_HOLD : ST_IDLE;
                        end else if (to_done) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            busy  <= 1'b1;
                            state <= ST_WAIT;
                        end
                    end
                    ST_HOLD: begin
                        if (!continuous) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (enter_start) begin
                            state         <= ST_START;
                            start_capture <= 1'b1;
                            busy          <= 1'b1;
                        end else begin
                            state <= ST_HOLD;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed bench for capture_scheduler: a short vector table for cycle-level
// behaviour plus hand-written sequences for the long multi-cycle cases.
module tb_capture_scheduler;
    import capture_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        enable, continuous, sw_trigger, clear_err, capture_complete;
    logic [15:0] period;
    logic        start_capture, busy, frame_done, overrun, timeout_err;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    capture_scheduler #(.PERIOD_W(16), .TIMEOUT_CYC(1024), .FCNT_W(16)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .enable           (enable),
        .continuous       (continuous),
        .sw_trigger       (sw_trigger),
        .period           (period),
        .clear_err        (clear_err),
        .capture_complete (capture_complete),
        .start_capture    (start_capture),
        .busy             (busy),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .overrun          (overrun),
        .timeout_err      (timeout_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  in_bits;   // {enable, continuous, sw_trigger, clear_err, capture_complete}
        logic [15:0] per;
        logic [4:0]  exp_bits;  // {start_capture, busy, frame_done, overrun, timeout_err}
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs [22];

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        enable = 1'b0; continuous = 1'b0; sw_trigger = 1'b0;
        clear_err = 1'b0; capture_complete = 1'b0; period = 16'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_in = 1'b1;
        repeat (3) step();
        reset_in = 1'b0;
    endtask

    task automatic wait_start(input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (start_capture) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int s, st, nstart;
        vecs[0]  = '{5'b00100, 16'd0, 5'b00000, 16'd0};
        vecs[1]  = '{5'b10001, 16'd0, 5'b00000, 16'd0};
        vecs[2]  = '{5'b10100, 16'd0, 5'b11000, 16'd0};
        vecs[3]  = '{5'b10000, 16'd0, 5'b01000, 16'd0};
        vecs[4]  = '{5'b10100, 16'd0, 5'b01010, 16'd0};
        vecs[5]  = '{5'b10010, 16'd0, 5'b01000, 16'd0};
        vecs[6]  = '{5'b10001, 16'd0, 5'b00100, 16'd1};
        vecs[7]  = '{5'b10000, 16'd0, 5'b00000, 16'd1};
        vecs[8]  = '{5'b10100, 16'd0, 5'b11000, 16'd1};
        vecs[9]  = '{5'b10110, 16'd0, 5'b01010, 16'd1};
        vecs[10] = '{5'b00000, 16'd0, 5'b00010, 16'd1};
        vecs[11] = '{5'b10001, 16'd0, 5'b00010, 16'd1};
        vecs[12] = '{5'b10010, 16'd0, 5'b00000, 16'd1};
        vecs[13] = '{5'b11000, 16'd5, 5'b11000, 16'd1};
        vecs[14] = '{5'b11000, 16'd5, 5'b01000, 16'd1};
        vecs[15] = '{5'b11001, 16'd5, 5'b00100, 16'd2};
        vecs[16] = '{5'b11100, 16'd5, 5'b00000, 16'd2};
        vecs[17] = '{5'b11000, 16'd5, 5'b00000, 16'd2};
        vecs[18] = '{5'b11000, 16'd5, 5'b11000, 16'd2};
        vecs[19] = '{5'b10000, 16'd5, 5'b01000, 16'd2};
        vecs[20] = '{5'b10001, 16'd5, 5'b00100, 16'd3};
        vecs[21] = '{5'b10000, 16'd5, 5'b00000, 16'd3};

        // Reset state
        do_reset();
        chk("rst_start", start_capture, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_tmo", timeout_err, 0);

        // Short cycle-level vectors
        for (int i = 0; i < 22; i++) begin
            {enable, continuous, sw_trigger, clear_err, capture_complete} = vecs[i].in_bits;
            period = vecs[i].per;
            step();
            chk($sformatf("vec%0d_start", i), start_capture, int'(vecs[i].exp_bits[4]));
            chk($sformatf("vec%0d_busy", i), busy, int'(vecs[i].exp_bits[3]));
            chk($sformatf("vec%0d_fd", i), frame_done, int'(vecs[i].exp_bits[2]));
            chk($sformatf("vec%0d_ovr", i), overrun, int'(vecs[i].exp_bits[1]));
            chk($sformatf("vec%0d_tmo", i), timeout_err, int'(vecs[i].exp_bits[0]));
            chk($sformatf("vec%0d_fc", i), frame_count, int'(vecs[i].exp_fc));
        end
        idle_inputs();

        // Reset held 3 cycles mid-WAIT with a sticky error pending
        enable = 1'b1; sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        step(); step();
        sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        chk("pre_rst_ovr", overrun, 1);
        reset_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstw_busy", busy, 0);
            chk("rstw_fc", frame_count, 0);
            chk("rstw_ovr", overrun, 0);
        end
        reset_in = 1'b0; enable = 1'b0; continuous = 1'b1;
        nstart = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (start_capture || busy) nstart++;
        end
        chk("rst_no_start", nstart, 0);

        // Single-shot: trigger -> start next cycle, complete 577 cycles later
        do_reset();
        enable = 1'b1; sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        chk("ss_start", start_capture, 1);
        s = cyc;
        step();
        chk("ss_start_pulse", start_capture, 0);
        while (cyc < s + SENSOR_CYCLE_LEN) step();
        chk("ss_busy", busy, 1);
        capture_complete = 1'b1;
        step();
        capture_complete = 1'b0;
        chk("ss_fd", frame_done, 1);
        chk("ss_fc", frame_count, 1);
        chk("ss_busy_end", busy, 0);
        step();
        chk("ss_fd_pulse", frame_done, 0);

        // Continuous, period 1000
        do_reset();
        enable = 1'b1; continuous = 1'b1; period = 16'd1000;
        step();
        chk("c1k_start0", start_capture, 1);
        s = cyc; st = cyc;
        for (int f = 0; f < 3; f++) begin
            while (cyc < st + SENSOR_CYCLE_LEN) step();
            capture_complete = 1'b1;
            step();
            capture_complete = 1'b0;
            chk("c1k_fd", frame_done, 1);
            chk("c1k_fc", frame_count, f + 1);
            if (f < 2) begin
                wait_start(1000, st);
                chk("c1k_start_at", st, s + (f + 1) * 1000);
            end
        end
        continuous = 1'b0;
        step();
        chk("c1k_ovr", overrun, 0);
        chk("c1k_fc3", frame_count, 3);

        // Continuous, period 100: back-to-back with overrun
        do_reset();
        enable = 1'b1; continuous = 1'b1; period = 16'd100;
        step();
        s = cyc;
        repeat (99) step();
        chk("c100_ovr_pre", overrun, 0);
        step();
        chk("c100_ovr_set", overrun, 1);
        while (cyc < s + SENSOR_CYCLE_LEN) step();
        capture_complete = 1'b1;
        step();
        capture_complete = 1'b0;
        chk("c100_fd", frame_done, 1);
        wait_start(10, st);
        chk("c100_b2b", st, s + SENSOR_CYCLE_LEN + 2);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("c100_clr", overrun, 0);
        while (cyc < st + 99) step();
        chk("c100_ovr_pre2", overrun, 0);
        step();
        chk("c100_ovr_reset", overrun, 1);
        capture_complete = 1'b1; continuous = 1'b0;
        step();
        capture_complete = 1'b0;
        chk("c100_fc", frame_count, 2);

        // Timeout, late completion, and completion racing the timeout
        do_reset();
        enable = 1'b1; sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        s = cyc;
        while (cyc < s + 1023) step();
        chk("to_pre", timeout_err, 0);
        chk("to_busy_pre", busy, 1);
        step();
        chk("to_set", timeout_err, 1);
        chk("to_busy", busy, 0);
        capture_complete = 1'b1;
        step();
        capture_complete = 1'b0;
        chk("to_late_fd", frame_done, 0);
        chk("to_late_fc", frame_count, 0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("to_clr", timeout_err, 0);
        sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        s = cyc;
        while (cyc < s + 1023) step();
        capture_complete = 1'b1;
        step();
        capture_complete = 1'b0;
        chk("race_fd", frame_done, 1);
        chk("race_tmo", timeout_err, 0);
        chk("race_fc", frame_count, 1);

        // Abort during WAIT, then trigger while busy
        do_reset();
        enable = 1'b1; sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        step(); step();
        enable = 1'b0;
        step();
        chk("ab_busy", busy, 0);
        enable = 1'b1; capture_complete = 1'b1;
        step();
        capture_complete = 1'b0;
        chk("ab_fd", frame_done, 0);
        chk("ab_fc", frame_count, 0);
        sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        step();
        sw_trigger = 1'b1;
        step();
        sw_trigger = 1'b0;
        chk("ab_ovr", overrun, 1);
        chk("ab_busy2", busy, 1);
        nstart = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (start_capture) nstart++;
        end
        chk("ab_no_second", nstart, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
